// File: rtl/exe_muldiv_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | exe_muldiv_unit: multi-cycle RV M-extension MUL/DIV/REM engine for EXE.  |
// | Define EXE_MULDIV_FAST_MUL_EN for a single-cycle multiplier.              |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module exe_muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [XLEN-1:0]  in_src1,
  input  logic [XLEN-1:0]  in_src2,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int CNT_W = $clog2(XLEN);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0] SIGNED_MIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [1:0]          op_q, op_d;
  logic [TAG_W-1:0]    tag_q, tag_d;
  logic [XLEN-1:0]     a_q, a_d;
  logic [XLEN-1:0]     b_q, b_d;
  logic                neg_q, neg_d;
  logic                dsign_q, dsign_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [XLEN-1:0]     result_q, result_d;

  // Full product is negated as a whole, then the requested half is picked.
  function automatic logic [XLEN-1:0] mul_fix(input logic [1:0] op, input logic neg,
                                              input logic [2*XLEN-1:0] prod);
    logic [2*XLEN-1:0] p;
    p = neg ? -prod : prod;
    return (op == 2'd0) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
  endfunction

  logic            w_accept;
  logic            w_sign1, w_sign2;
  logic [XLEN-1:0] w_mag1, w_mag2;
  logic            w_div_zero, w_div_ovf;

  assign in_ready  = !flush && ((state_q == S_IDLE) || ((state_q == S_DONE) && out_ready));
  assign w_accept  = in_valid && in_ready;
  assign out_valid = (state_q == S_DONE);
  assign out_result = result_q;
  assign out_tag   = tag_q;
  assign busy      = (state_q == S_MUL) || (state_q == S_DIV);

  // src1 is signed for MULH/MULHSU/DIV/REM; src2 for MULH/DIV/REM.
  assign w_sign1 = in_src1[XLEN-1] &&
                   ((in_op == 3'd1) || (in_op == 3'd2) || (in_op == 3'd4) || (in_op == 3'd6));
  assign w_sign2 = in_src2[XLEN-1] &&
                   ((in_op == 3'd1) || (in_op == 3'd4) || (in_op == 3'd6));
  assign w_mag1  = w_sign1 ? -in_src1 : in_src1;
  assign w_mag2  = w_sign2 ? -in_src2 : in_src2;

  assign w_div_zero = (in_src2 == '0);
  assign w_div_ovf  = !in_op[0] && (in_src1 == SIGNED_MIN) && (in_src2 == '1);

  // Shift-add: upper half accumulates, lower half holds remaining multiplier bits.
  logic [XLEN:0]     w_mul_sum;
  logic [2*XLEN-1:0] w_mul_step;
  assign w_mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + ({1'b0, a_q} & {(XLEN+1){acc_q[0]}});
  assign w_mul_step = {w_mul_sum, acc_q[XLEN-1:1]};

  // Restoring divide: upper half is the partial remainder, lower half fills with quotient.
  logic [XLEN:0]     w_div_sh, w_div_trial;
  logic [2*XLEN-1:0] w_div_step;
  assign w_div_sh    = acc_q[2*XLEN-1:XLEN-1];
  assign w_div_trial = w_div_sh - {1'b0, b_q};
  assign w_div_step  = w_div_trial[XLEN] ? {w_div_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                         : {w_div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};

  logic [XLEN-1:0] w_mul_res, w_div_res;
  assign w_mul_res = mul_fix(op_q, neg_q, w_mul_step);
  assign w_div_res = op_q[1] ? (dsign_q ? -w_div_step[2*XLEN-1:XLEN] : w_div_step[2*XLEN-1:XLEN])
                             : (neg_q ? -w_div_step[XLEN-1:0] : w_div_step[XLEN-1:0]);

`ifdef EXE_MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] w_fast_prod;
  logic [XLEN-1:0]   w_fast_res;
  assign w_fast_prod = (2*XLEN)'(w_mag1) * (2*XLEN)'(w_mag2);
  assign w_fast_res  = mul_fix(in_op[1:0], w_sign1 ^ w_sign2, w_fast_prod);
`endif

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    tag_d    = tag_q;
    a_d      = a_q;
    b_d      = b_q;
    neg_d    = neg_q;
    dsign_d  = dsign_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    result_d = result_q;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_MUL: begin
          acc_d = w_mul_step;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST) begin
            state_d  = S_DONE;
            result_d = w_mul_res;
          end
        end
        S_DIV: begin
          acc_d = w_div_step;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST) begin
            state_d  = S_DONE;
            result_d = w_div_res;
          end
        end
        S_DONE: begin
          if (out_ready) state_d = S_IDLE;
        end
        default: ;
      endcase
      // Accept overrides the DONE->IDLE handoff so back-to-back issue reloads.
      if (w_accept) begin
        op_d    = in_op[1:0];
        tag_d   = in_tag;
        a_d     = w_mag1;
        b_d     = w_mag2;
        neg_d   = w_sign1 ^ w_sign2;
        dsign_d = w_sign1;
        cnt_d   = '0;
        if (!in_op[2]) begin
          acc_d = {{XLEN{1'b0}}, w_mag2};
`ifdef EXE_MULDIV_FAST_MUL_EN
          state_d  = S_DONE;
          result_d = w_fast_res;
`else
          state_d  = S_MUL;
`endif
        end else if (w_div_zero) begin
          state_d  = S_DONE;
          result_d = in_op[1] ? in_src1 : '1;
        end else if (w_div_ovf) begin
          state_d  = S_DONE;
          result_d = in_op[1] ? '0 : in_src1;
        end else begin
          acc_d   = {{XLEN{1'b0}}, w_mag1};
          state_d = S_DIV;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      tag_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      neg_q    <= 1'b0;
      dsign_q  <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      tag_q    <= tag_d;
      a_q      <= a_d;
      b_q      <= b_d;
      neg_q    <= neg_d;
      dsign_q  <= dsign_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      result_q <= result_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_exe_muldiv_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_exe_muldiv_unit: directed self-checking bench for exe_muldiv_unit.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_exe_muldiv_unit;

`ifdef EXE_MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [31:0] in_src1;
  logic [31:0] in_src2;
  logic [4:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_tag;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  exe_muldiv_unit #(.XLEN(32), .TAG_W(5)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_src1(in_src1), .in_src2(in_src2), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_tag(out_tag), .busy(busy)
  );

  always #5 clk = ~clk;

  // Called at posedge+1; returns at posedge+1 of the cycle after the accept edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] tag);
    int guard;
    in_valid = 1'b1; in_op = op; in_src1 = a; in_src2 = b; in_tag = tag;
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) begin
      checks++; failures++;
      $display("FAIL accept_timeout op=%0d in_ready=%b required=1", op, in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] tag,
                        input logic [31:0] exp, input int exp_lat);
    int lat;
    out_ready = 1'b1;
    issue(op, a, b, tag);
    wait_valid(lat);
    checks++;
    if (out_result !== exp) begin
      failures++;
      $display("FAIL %s result got=%h expected=%h", name, out_result, exp);
    end
    checks++;
    if (out_tag !== tag) begin
      failures++;
      $display("FAIL %s tag got=%0d expected=%0d", name, out_tag, tag);
    end
    checks++;
    if (lat != exp_lat) begin
      failures++;
      $display("FAIL %s latency got=%0d expected=%0d", name, lat, exp_lat);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_op = 3'd0;
    in_src1 = '0; in_src2 = '0; in_tag = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || out_result !== 32'h0 || out_tag !== 5'd0) begin
      failures++;
      $display("FAIL reset_outputs got v=%b busy=%b res=%h tag=%0d expected 0 0 0 0",
               out_valid, busy, out_result, out_tag);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready got=%b expected=1", in_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_divu();
    int lat;
    out_ready = 1'b1;
    issue(3'd5, 32'd100, 32'd7, 5'd3);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL divu_busy got=%b expected=1", busy);
    end
    wait_valid(lat);
    checks++;
    if (out_result !== 32'd14 || lat != DIV_LAT) begin
      failures++;
      $display("FAIL divu_100_7 result=%0d lat=%0d expected 14 lat %0d", out_result, lat, DIV_LAT);
    end
    @(posedge clk); #1;
    run_op("remu_100_7", 3'd7, 32'd100, 32'd7, 5'd4, 32'd2, DIV_LAT);
    run_op("divu_big", 3'd5, 32'hFFFFFFFF, 32'h10, 5'd5, 32'h0FFFFFFF, DIV_LAT);
  endtask

  task automatic test_div_signed();
    run_op("div_m7_2", 3'd4, 32'hFFFFFFF9, 32'd2, 5'd6, 32'hFFFFFFFD, DIV_LAT);
    run_op("rem_m7_2", 3'd6, 32'hFFFFFFF9, 32'd2, 5'd7, 32'hFFFFFFFF, DIV_LAT);
    run_op("rem_7_m2", 3'd6, 32'd7, 32'hFFFFFFFE, 5'd8, 32'd1, DIV_LAT);
  endtask

  task automatic test_div_edge();
    run_op("div_by_zero", 3'd4, 32'd5, 32'd0, 5'd9, 32'hFFFFFFFF, 1);
    run_op("remu_by_zero", 3'd7, 32'd5, 32'd0, 5'd10, 32'd5, 1);
    run_op("div_overflow", 3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd11, 32'h80000000, 1);
    run_op("rem_overflow", 3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd12, 32'h0, 1);
  endtask

  task automatic test_mul();
    run_op("mul_ones", 3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd13, 32'h1, MUL_LAT);
    run_op("mulh_ones", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd14, 32'h0, MUL_LAT);
    run_op("mulhu_ones", 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd15, 32'hFFFFFFFE, MUL_LAT);
    run_op("mulhsu_ones", 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd16, 32'hFFFFFFFF, MUL_LAT);
    run_op("mul_6_m7", 3'd0, 32'd6, 32'hFFFFFFF9, 5'd17, 32'hFFFFFFD6, MUL_LAT);
  endtask

  task automatic test_flush();
    int rises;
    out_ready = 1'b1;
    issue(3'd4, 32'd1000, 32'd3, 5'd18);
    repeat (9) begin
      @(posedge clk); #1;
    end
    flush = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL flush_in_ready_during got=%b expected=0", in_ready);
    end
    @(posedge clk); #1;
    flush = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL flush_abort busy=%b in_ready=%b expected busy=0 in_ready=1", busy, in_ready);
    end
    rises = 0;
    repeat (40) begin
      if (out_valid) rises++;
      @(posedge clk); #1;
    end
    checks++;
    if (rises != 0) begin
      failures++;
      $display("FAIL flush_no_valid got=%0d valid cycles expected=0", rises);
    end
    run_op("divu_after_flush", 3'd5, 32'd9, 32'd3, 5'd19, 32'd3, DIV_LAT);
  endtask

  task automatic test_back_to_back();
    int lat;
    int unstable;
    out_ready = 1'b0;
    issue(3'd7, 32'd50, 32'd7, 5'd20);
    wait_valid(lat);
    unstable = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (!out_valid || out_result !== 32'd1 || out_tag !== 5'd20) unstable++;
    end
    checks++;
    if (unstable != 0 || lat != DIV_LAT) begin
      failures++;
      $display("FAIL backpressure_hold unstable=%0d lat=%0d expected 0 lat %0d", unstable, lat, DIV_LAT);
    end
    out_ready = 1'b1;
    in_valid = 1'b1; in_op = 3'd3; in_src1 = 32'h10000; in_src2 = 32'h10000; in_tag = 5'd21;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL b2b_in_ready got=%b expected=1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_valid(lat);
    checks++;
    if (out_result !== 32'h1 || out_tag !== 5'd21 || lat != MUL_LAT) begin
      failures++;
      $display("FAIL b2b_next result=%h tag=%0d lat=%0d expected 1 21 %0d",
               out_result, out_tag, lat, MUL_LAT);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_divu();
    test_div_signed();
    test_div_edge();
    test_mul();
    test_flush();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/exe_muldiv_unit.md
# exe_muldiv_unit

Parametrised multi-cycle RISC-V M-extension unit for the EXE stage. It replaces the fixed mul/div datapath with one engine that handles all eight MUL/DIV/REM ops at any XLEN. Operands enter and results leave through valid/ready handshakes, and system flush is honoured. It sits beside the ALU: EXE issues the op, holds its `ready_go` low until `out_valid`, then forwards `out_result` to MEM.

## Interface
- `XLEN`, 32: operand/result width; any even value ≥ 8.
- `TAG_W`, 5: width of the sideband tag carried with each op (rd index).
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `flush` in 1: system flush; aborts any op in flight.
- `in_valid` in 1: op request.
- `in_ready` out 1: unit accepts the op this cycle.
- `in_op` in 3: RISC-V funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- `in_src1` in XLEN: rs1 operand (multiplicand/dividend).
- `in_src2` in XLEN: rs2 operand (multiplier/divisor).
- `in_tag` in TAG_W: sideband tag, returned unchanged.
- `out_valid` out 1: result available.
- `out_ready` in 1: consumer takes the result.
- `out_result` out XLEN: result.
- `out_tag` out TAG_W: tag of that result.
- `busy` out 1: iterating (state MUL or DIV).

## Operation
- States:
  - IDLE: no op held.
  - MUL: iterative multiply in progress.
  - DIV: iterative divide in progress.
  - DONE: result held.
- Accept: `in_valid && in_ready`. `in_ready = !flush && (IDLE || (DONE && out_ready))`, so back-to-back issue is allowed on result handoff.
- On accept, the unit latches op, tag, operand magnitudes, result-sign flag and dividend sign, clears the counter, then moves to:
  - MUL for ops 0–3, when FAST_MUL_EN is off;
  - DONE directly for ops 0–3 when FAST_MUL_EN is on, and for the divide special cases below;
  - DIV otherwise.
- Signedness:
  - MULH, DIV, REM: both operands signed.
  - MULHSU: src1 signed, src2 unsigned.
  - MULHU, DIVU, REMU: both operands unsigned.
  - MUL: low half; sign is irrelevant to the result.
- The engine works on unsigned magnitudes and applies a two's-complement fix at DONE:
  - Product: negated when the operand signs differ.
  - Quotient: negated when the operand signs differ.
  - Remainder: takes the dividend's sign.
- MUL: shift-add on a 2·XLEN accumulator, one multiplier bit per cycle, XLEN cycles. Op 0 returns the low half; ops 1–3 return the high half.
- DIV: restoring radix-2, one quotient bit per cycle, XLEN cycles.
- Divide special cases, resolved at accept with no iteration:
  - Divisor 0: quotient = all ones; remainder = src1.
  - Signed overflow (src1 = 1 followed by XLEN-1 zeros, i.e. signed minimum; src2 = all ones): quotient = src1; remainder = 0.
- DONE: `out_valid = 1`; result and tag are held stable until `out_ready`. Then the unit returns to IDLE, or reloads if a new op is accepted in the same cycle.
- `flush`: from any state, the unit goes to IDLE next cycle, `out_valid` drops, the held result is discarded, and no accept occurs in the flush cycle.
- Reset:
  - State IDLE, counter 0.
  - `out_valid`=0, `out_result`=0, `out_tag`=0, `busy`=0.
  - `in_ready`=1 in the first cycle after reset release.

## Timing
- Accept at cycle T.
  - Iterative MUL/DIV: `busy`=1 for T+1…T+XLEN; `out_valid` rises at T+XLEN+1 (T+33 when XLEN=32).
  - Fast multiply or divide special case: `out_valid` at T+1.
- `out_valid` and `out_result` are registered-state driven with no combinational path from `in_*`. `in_ready` depends combinationally on `out_ready` and `flush` only.
- Under backpressure (`out_ready`=0), DONE persists indefinitely and the outputs do not change.
- Reset has priority over flush, and flush has priority over accept and handoff.
- Reset or flush mid-iteration: abort next cycle, and the counter restarts from 0 on the next accept.

## Configuration
- `EXE_MULDIV_FAST_MUL_EN` defined: ops 0–3 use a single-cycle combinational XLEN×XLEN multiplier registered into DONE, with latency 1; the MUL state is unreachable.
- Not defined: ops 0–3 use the iterative shift-add path with XLEN+1 cycle latency, and no hardware multiplier is inferred.
- Division is iterative in both builds.

## Test plan
- XLEN=32, DIVU 100, 7 -> `out_result`=14 and `out_valid` exactly at T+33. REMU on the same operands -> 2.
- DIV 0xFFFFFFF9 (-7), 2 -> 0xFFFFFFFD (-3). REM on the same operands -> 0xFFFFFFFF (-1).
- Edge divides, each with `out_valid` at T+1:
  - DIV 5, 0 -> 0xFFFFFFFF.
  - REMU 5, 0 -> 5.
  - DIV 0x80000000, 0xFFFFFFFF -> 0x80000000.
  - REM on the same operands -> 0.
- Multiplies, checked in both macro builds:
  - MUL 0xFFFFFFFF, 0xFFFFFFFF -> 1.
  - MULH on the same operands -> 0.
  - MULHU on the same operands -> 0xFFFFFFFE.
  - MULHSU on the same operands -> 0xFFFFFFFF.
- Flush at T+10 of a DIV -> `busy`=0 and `in_ready`=1 at T+11; `out_valid` never rises. The next op (DIVU 9, 3) returns 3 with a correct tag.
- Hold `out_ready`=0 for 5 cycles in DONE -> result and tag stable. Then, in one cycle, assert `out_ready` and issue the next op -> the next op is accepted and its result follows with correct latency.
